// File: rtl/guess_entry_pkg.sv
// Shared types and constants for the guess_entry digit-entry stage.
package guess_entry_pkg;

    localparam int NUM_DIGITS = 3;
    localparam int DIGIT_W    = 4;
    localparam int LEN_W      = 2;
    localparam int MAX_DIGIT  = 9;

    typedef enum logic [2:0] {
        ST_EMPTY  = 3'd0,
        ST_PART   = 3'd1,
        ST_FULL   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_LOCK   = 3'd4
    } state_t;

    function automatic logic has_dup(input logic [DIGIT_W-1:0] a,
                                     input logic [DIGIT_W-1:0] b,
                                     input logic [DIGIT_W-1:0] c);
        return (a == b) || (a == c) || (b == c);
    endfunction

endpackage

// File: rtl/entry_buffer.sv
// Three-slot decimal edit buffer with append, backspace and clear.
// Clear wins over append/backspace; the caller guarantees at most one request per cycle.
module entry_buffer
    import guess_entry_pkg::*;
(
    input  logic               CLK,
    input  logic               reset,
    input  logic               append,
    input  logic               back,
    input  logic               clear,
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] slots [NUM_DIGITS],
    output logic [LEN_W-1:0]   len
);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) slots[i] <= '0;
            len <= '0;
        end else if (append && len < LEN_W'(NUM_DIGITS)) begin
            for (int i = 0; i < NUM_DIGITS; i++)
                if (len == LEN_W'(i)) slots[i] <= digit;
            len <= len + 1'b1;
        end else if (back && len != '0) begin
            // vacated slot returns to 0 so a later commit never sees stale digits
            for (int i = 0; i < NUM_DIGITS; i++)
                if (len == LEN_W'(i + 1)) slots[i] <= '0;
            len <= len - 1'b1;
        end
    end

endmodule

// File: rtl/guess_entry.sv
// Digit-entry FSM: collects three digits, validates on Enter, commits answer then guesses.
// Optional GUESS_DUP_CHECK_EN rejects entries containing a repeated digit.
module guess_entry
    import guess_entry_pkg::*;
#(
    parameter int MAX_GUESS = 10
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_enter,
    input  logic               key_back,
    output logic [DIGIT_W-1:0] oNum1,
    output logic [DIGIT_W-1:0] oNum2,
    output logic [DIGIT_W-1:0] oNum3,
    output logic               oNumRdy,
    output logic [LEN_W-1:0]   oLen,
    output logic               oErr,
    output logic [3:0]         oGuessCnt,
    output logic               oLocked,
    output state_t             state_dbg
);

    // Strobes are single-cycle; key_back > key_enter > key_valid, one acts per cycle.
    state_t             state, state_next;
    logic               do_append, do_back, do_clear, do_commit, err_next;
    logic               entry_ok, answered;
    logic [LEN_W-1:0]   len, len_after;
    logic [DIGIT_W-1:0] slots [NUM_DIGITS];

    entry_buffer u_buf (
        .CLK    (CLK),
        .reset  (reset),
        .append (do_append),
        .back   (do_back),
        .clear  (do_clear),
        .digit  (key_digit),
        .slots  (slots),
        .len    (len)
    );

`ifdef GUESS_DUP_CHECK_EN
    assign entry_ok = !has_dup(slots[0], slots[1], slots[2]);
`else
    assign entry_ok = 1'b1;
`endif

    always_comb begin
        state_next = state;
        do_append  = 1'b0;
        do_back    = 1'b0;
        do_clear   = 1'b0;
        do_commit  = 1'b0;
        err_next   = 1'b0;
        len_after  = len;
        case (state)
            ST_EMPTY, ST_PART, ST_FULL: begin
                if (key_back) begin
                    if (len != '0) begin
                        do_back   = 1'b1;
                        len_after = len - 1'b1;
                    end
                end else if (key_enter) begin
                    if (state == ST_FULL && entry_ok) begin
                        do_commit = 1'b1;
                        do_clear  = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (key_valid && key_digit <= DIGIT_W'(MAX_DIGIT)
                             && len < LEN_W'(NUM_DIGITS)) begin
                    do_append = 1'b1;
                    len_after = len + 1'b1;
                end
                if (do_commit)                          state_next = ST_COMMIT;
                else if (len_after == '0)               state_next = ST_EMPTY;
                else if (len_after == LEN_W'(NUM_DIGITS)) state_next = ST_FULL;
                else                                    state_next = ST_PART;
            end
            // the counter increments on leaving COMMIT, so lock when it is one short
            ST_COMMIT: state_next = (answered && oGuessCnt == 4'(MAX_GUESS - 1)) ? ST_LOCK : ST_EMPTY;
            ST_LOCK:   state_next = ST_LOCK;
            default:   state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= ST_EMPTY;
            oNum1     <= '0;
            oNum2     <= '0;
            oNum3     <= '0;
            oNumRdy   <= 1'b0;
            oErr      <= 1'b0;
            oGuessCnt <= '0;
            oLocked   <= 1'b0;
            answered  <= 1'b0;
        end else begin
            state   <= state_next;
            oNumRdy <= do_commit;
            oErr    <= err_next;
            oLocked <= (state_next == ST_LOCK);
            if (do_commit) begin
                oNum1 <= slots[0];
                oNum2 <= slots[1];
                oNum3 <= slots[2];
            end
            if (state == ST_COMMIT) begin
                if (!answered)                          answered  <= 1'b1;
                else if (oGuessCnt != 4'(MAX_GUESS))    oGuessCnt <= oGuessCnt + 1'b1;
            end
        end
    end

    assign oLen      = len;
    assign state_dbg = state;

endmodule
